boot_image_sender: RTL and testbench

- Host-side counterpart of the FPGA bootloader.
- Streams a boot image from a synchronous word memory over UART, one 32-bit word per four bytes, most-significant byte first, so the bootloader's shift-left assembly reproduces each word at consecutive addresses.
- Concurrently reassembles the debug words returned by the FPGA (sent least-significant byte first) and presents them as 32-bit words with a valid strobe.
- Drives an external UART instance through its trmt/tx_data/tx_done and rx_rdy/rx_data/clr_rx_rdy handshake.

---
 rtl/boot_image_sender.sv | 185 ++++++++++++++++++
 tb/tb_boot_image_sender.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_image_sender.sv
// Streams a boot image from word memory over a UART (MSB first) and reassembles
// LSB-first debug words coming back. Define BOOT_CHECKSUM_EN to append a sum word.
module boot_image_sender #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_words,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              trmt,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              clr_rx_rdy,
    output logic [31:0]       dbg_word,
    output logic              dbg_valid
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_GUARD = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       shreg_q, shreg_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic              last_word;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
    logic              csum_phase_q, csum_phase_d;
`endif

    // Wraps modulo 2^ADDR_W, so the largest image is 2^ADDR_W-1 words.
    assign last_word = (addr_q + ADDR_W'(1)) == count_q;

    always_comb begin
        // NOTE: every next-state signal defaults to its register first, so no
        // branch of the case below can leave one unassigned and infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
`ifdef BOOT_CHECKSUM_EN
        sum_d        = sum_q;
        csum_phase_d = csum_phase_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        count_d = num_words;
                        addr_d  = '0;
                        state_d = S_FETCH;
`ifdef BOOT_CHECKSUM_EN
                        sum_d        = '0;
                        csum_phase_d = 1'b0;
`endif
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                shreg_d    = mem_rdata;
                byte_cnt_d = '0;
                state_d    = S_SEND;
`ifdef BOOT_CHECKSUM_EN
                sum_d = sum_q + mem_rdata;
`endif
            end
            S_SEND:  state_d = S_GUARD;
            // tx_done may still show the previous byte here, so it is ignored.
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done) begin
                    if (byte_cnt_q != 2'd3) begin
                        shreg_d    = shreg_q << 8;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        state_d    = S_SEND;
                    end else if (!last_word) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end else begin
`ifdef BOOT_CHECKSUM_EN
                        if (!csum_phase_q) begin
                            shreg_d      = sum_q;
                            byte_cnt_d   = '0;
                            csum_phase_d = 1'b1;
                            state_d      = S_SEND;
                        end else begin
                            state_d = S_FIN;
                        end
`else
                        state_d = S_FIN;
`endif
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= '0;
            csum_phase_q <= 1'b0;
`endif
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples
            // the pre-edge values, independent of statement order.
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= sum_d;
            csum_phase_q <= csum_phase_d;
`endif
        end
    end

    assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done     = (state_q == S_FIN);
    assign mem_rd   = (state_q == S_FETCH);
    assign trmt     = (state_q == S_SEND);
    assign mem_addr = addr_q;
    // Shift register only moves on entry to SEND, so the byte holds between trmts.
    assign tx_data  = shreg_q[31:24];

    logic [1:0]  rx_cnt_q;
    logic [31:0] rx_asm_q;
    logic        clr_q;
    logic [31:0] dbg_word_q;
    logic        dbg_valid_q;
    logic        rx_take;

    assign rx_take = rx_rdy && !clr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_q    <= '0;
            rx_asm_q    <= '0;
            clr_q       <= 1'b0;
            dbg_word_q  <= '0;
            dbg_valid_q <= 1'b0;
        end else begin
            clr_q       <= rx_take;
            dbg_valid_q <= 1'b0;
            if (rx_take) begin
                rx_asm_q[{rx_cnt_q, 3'b000} +: 8] <= rx_data;
                rx_cnt_q <= rx_cnt_q + 2'd1;
                if (rx_cnt_q == 2'd3) begin
                    dbg_word_q  <= {rx_data, rx_asm_q[23:0]};
                    dbg_valid_q <= 1'b1;
                end
            end
        end
    end

    assign clr_rx_rdy = clr_q;
    assign dbg_word   = dbg_word_q;
    assign dbg_valid  = dbg_valid_q;

endmodule

// File: tb/tb_boot_image_sender.sv
// Scoreboard bench for boot_image_sender: UART/memory models on the falling edge,
// expected tx bytes, read addresses and debug words queued and popped on output.
module tb_boot_image_sender;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] num_words = '0;
    logic              busy, done, mem_rd, trmt, clr_rx_rdy, dbg_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata = '0;
    logic [7:0]        tx_data;
    logic              tx_done = 1'b1;
    logic              rx_rdy = 1'b0;
    logic [7:0]        rx_data = '0;
    logic [31:0]       dbg_word;

    boot_image_sender #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
        .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
        .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
        .dbg_word(dbg_word), .dbg_valid(dbg_valid)
    );

    always #5 clk = ~clk;

    logic [31:0]       mem [0:15];
    logic [7:0]        tx_exp [$];
    logic [ADDR_W-1:0] addr_exp [$];
    logic [31:0]       dbg_exp [$];
    int tests_run = 0, failed = 0;
    int trmt_cnt = 0, rd_cnt = 0, done_cnt = 0, dbg_cnt = 0, tx_timer = 0;
    logic [31:0]       last4 = '0;
    logic [7:0]        eb;
    logic [ADDR_W-1:0] ea;
    logic [31:0]       ew;

    // UART transmitter, image memory and output monitors.
    always @(negedge clk) begin
        if (trmt) begin
            trmt_cnt++;
            last4 = {last4[23:0], tx_data};
            tests_run++;
            if (tx_exp.size() == 0) begin
                failed++;
                $display("FAIL tx_byte: got 0x%02h, expected no byte", tx_data);
            end else begin
                eb = tx_exp.pop_front();
                if (tx_data !== eb) begin
                    failed++;
                    $display("FAIL tx_byte: got 0x%02h, expected 0x%02h", tx_data, eb);
                end
            end
            tx_done  = 1'b0;
            tx_timer = 10;
        end else if (tx_timer > 0) begin
            tx_timer--;
            if (tx_timer == 0) tx_done = 1'b1;
        end
        if (mem_rd) begin
            rd_cnt++;
            tests_run++;
            if (addr_exp.size() == 0) begin
                failed++;
                $display("FAIL mem_addr: read at %0d, expected no read", mem_addr);
            end else begin
                ea = addr_exp.pop_front();
                if (mem_addr !== ea) begin
                    failed++;
                    $display("FAIL mem_addr: got %0d, expected %0d", mem_addr, ea);
                end
            end
            mem_rdata = mem[mem_addr[3:0]];
        end
        if (done) done_cnt++;
        if (dbg_valid) begin
            dbg_cnt++;
            tests_run++;
            if (dbg_exp.size() == 0) begin
                failed++;
                $display("FAIL dbg_word: got 0x%08h, expected no word", dbg_word);
            end else begin
                ew = dbg_exp.pop_front();
                if (dbg_word !== ew) begin
                    failed++;
                    $display("FAIL dbg_word: got 0x%08h, expected 0x%08h", dbg_word, ew);
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) tx_exp.push_back(w[8*b +: 8]);
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] n);
        @(negedge clk);
        start = 1'b1;
        num_words = n;
        @(negedge clk);
        start = 1'b0;
        num_words = ~n;
    endtask

    task automatic wait_done(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (i == budget) begin
            tests_run++;
            failed++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_trmts(input int target, input string name);
        int i;
        for (i = 0; i < 500; i++) begin
            if (trmt_cnt >= target) break;
            @(negedge clk);
        end
        if (i == 500) begin
            tests_run++;
            failed++;
            $display("FAIL %s_timeout: trmt count %0d, expected %0d", name, trmt_cnt, target);
        end
    endtask

    // Queues the expected stream for mem[0..n-1]; optionally pokes start mid-transfer.
    task automatic run_image(input int n, input bit poke, input string name);
        int rd0 = rd_cnt, dn0 = done_cnt, tr0 = trmt_cnt;
        logic [31:0] sum = '0;
        for (int i = 0; i < n; i++) begin
            addr_exp.push_back(ADDR_W'(i));
            push_word(mem[i]);
            sum += mem[i];
        end
`ifdef BOOT_CHECKSUM_EN
        push_word(sum);
`endif
        pulse_start(ADDR_W'(n));
        if (poke) begin
            wait_trmts(tr0 + 1, name);
            pulse_start(ADDR_W'(1));
        end
        wait_done((n + 1) * 80 + 50, name);
        repeat (30) @(negedge clk);
        tests_run++;
        if (tx_exp.size() !== 0) begin
            failed++;
            $display("FAIL %s_bytes: %0d bytes missing, expected 0", name, tx_exp.size());
        end
        tests_run++;
        if (rd_cnt - rd0 !== n) begin
            failed++;
            $display("FAIL %s_reads: got %0d mem_rd, expected %0d", name, rd_cnt - rd0, n);
        end
        tests_run++;
        if (done_cnt - dn0 !== 1) begin
            failed++;
            $display("FAIL %s_done: got %0d done pulses, expected 1", name, done_cnt - dn0);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL %s_busy: got %b, expected 0", name, busy);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        int i;
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = b;
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            if (clr_rx_rdy) break;
        end
        if (i == 10) begin
            tests_run++;
            failed++;
            $display("FAIL rx_ack: no clr_rx_rdy for byte 0x%02h", b);
        end
        rx_rdy = 1'b0;
        @(negedge clk);
    endtask

    task automatic rx_word(input logic [31:0] w, input string name);
        int d0 = dbg_cnt;
        dbg_exp.push_back(w);
        for (int b = 0; b < 4; b++) send_rx(w[8*b +: 8]);
        repeat (3) @(negedge clk);
        tests_run++;
        if (dbg_cnt - d0 !== 1) begin
            failed++;
            $display("FAIL %s_valid: got %0d dbg_valid pulses, expected 1", name, dbg_cnt - d0);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests_run++;
        if ({busy, done, mem_rd, trmt, clr_rx_rdy, dbg_valid} !== 6'b0) begin
            failed++;
            $display("FAIL reset_ctrl: got %b, expected 000000",
                     {busy, done, mem_rd, trmt, clr_rx_rdy, dbg_valid});
        end
        tests_run++;
        if ({mem_addr, tx_data, dbg_word} !== '0) begin
            failed++;
            $display("FAIL reset_data: addr %0d tx 0x%02h dbg 0x%08h, expected 0",
                     mem_addr, tx_data, dbg_word);
        end
    endtask

    task automatic test_single_word;
        mem[0] = 32'hDEADBEEF;
        run_image(1, 1'b0, "single");
    endtask

    task automatic test_three_words;
        mem[0] = 32'h01020304;
        mem[1] = 32'h05060708;
        mem[2] = 32'h090A0B0C;
        run_image(3, 1'b0, "three");
    endtask

    task automatic test_rx;
        rx_word(32'h12345678, "rx_first");
        rx_word(32'hDDCCBBAA, "rx_second");
    endtask

    task automatic test_zero_length;
        int tr0 = trmt_cnt, rd0 = rd_cnt, dn0 = done_cnt;
        pulse_start('0);
        tests_run++;
        if ({done, busy} !== 2'b10) begin
            failed++;
            $display("FAIL zero_done: got done=%b busy=%b, expected done=1 busy=0", done, busy);
        end
        repeat (20) @(negedge clk);
        tests_run++;
        if ({trmt_cnt - tr0, rd_cnt - rd0, done_cnt - dn0} !== {32'd0, 32'd0, 32'd1}) begin
            failed++;
            $display("FAIL zero_counts: trmt %0d rd %0d done %0d, expected 0 0 1",
                     trmt_cnt - tr0, rd_cnt - rd0, done_cnt - dn0);
        end
    endtask

    task automatic test_start_while_busy;
        mem[0] = 32'h11223344;
        mem[1] = 32'h55667788;
        run_image(2, 1'b1, "busy_start");
    endtask

    task automatic test_reset_mid;
        int tr0 = trmt_cnt;
        mem[0] = 32'hA1A2A3A4;
        mem[1] = 32'hB1B2B3B4;
        addr_exp.push_back('0);
        push_word(mem[0]);
        pulse_start(ADDR_W'(2));
        send_rx(8'h99);
        send_rx(8'h88);
        wait_trmts(tr0 + 2, "mid");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, mem_rd, trmt, clr_rx_rdy, dbg_valid, mem_addr, tx_data, dbg_word} !== '0) begin
            failed++;
            $display("FAIL mid_reset_outputs: busy %b addr %0d tx 0x%02h dbg 0x%08h, expected 0",
                     busy, mem_addr, tx_data, dbg_word);
        end
        tx_exp.delete();
        addr_exp.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        tests_run++;
        if (done_cnt != 0 && done) begin
            failed++;
            $display("FAIL mid_no_done: done pulsed after reset, expected none");
        end
        mem[0] = 32'hC1C2C3C4;
        mem[1] = 32'hD1D2D3D4;
        run_image(2, 1'b0, "after_reset");
        rx_word(32'h44332211, "rx_fresh");
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum;
        mem[0] = 32'h00000001;
        mem[1] = 32'hFFFFFFFF;
        run_image(2, 1'b0, "checksum");
        tests_run++;
        if (last4 !== 32'h00000000) begin
            failed++;
            $display("FAIL checksum_word: got 0x%08h, expected 0x00000000", last4);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single_word();
        test_three_words();
        test_rx();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        tests_run++;
        if (dbg_exp.size() !== 0) begin
            failed++;
            $display("FAIL dbg_pending: %0d words not produced, expected 0", dbg_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
